// File: rtl/program_loader_if.sv
// program_loader_if: bundles the host instruction stream, the steering-stage
// code-RAM/run handshake and the result port of the program loader.
// With PROGRAM_LOADER_WATCHDOG_EN defined the res_timeout flag is added.
interface program_loader_if #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 10
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [N-1:0] ld_data;
    logic [M-1:0] ld_addr;
    logic         ld_wr;
    logic         start;
    logic [N-1:0] calc_out;
    logic         calc_ready;
    logic [N-1:0] res_data;
    logic         res_valid;
    logic         res_ready;
    logic [M-1:0] prog_len;
    logic         err_ovf;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
    logic         res_timeout;
`endif

    // Loader side
    modport master (
        input  in_data, in_valid, in_last, calc_out, calc_ready, res_ready,
        output in_ready, ld_data, ld_addr, ld_wr, start, res_data, res_valid,
        output prog_len, err_ovf
`ifdef PROGRAM_LOADER_WATCHDOG_EN
        , output res_timeout
`endif
    );

    // Host / steering side
    modport slave (
        output in_data, in_valid, in_last, calc_out, calc_ready, res_ready,
        input  in_ready, ld_data, ld_addr, ld_wr, start, res_data, res_valid,
        input  prog_len, err_ovf
`ifdef PROGRAM_LOADER_WATCHDOG_EN
        , input res_timeout
`endif
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: streams a program into the steering stage code RAM from
// address 0, pulses start, waits for the run to finish and returns the
// calculator top-of-stack on a valid/ready result port.
// Optional feature: define PROGRAM_LOADER_WATCHDOG_EN to add a watchdog
// (parameter WD_CYCLES) on the wait states and the res_timeout flag.
module program_loader #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 10
`ifdef PROGRAM_LOADER_WATCHDOG_EN
    , parameter int unsigned WD_CYCLES = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.master bus
);

    localparam logic [M-1:0] WPTR_MAX = '1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESULT
    } state_t;

    state_t       state;
    logic [M-1:0] wptr;
    logic         accept_c;

`ifdef PROGRAM_LOADER_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit_c;

    // Watchdog expires on the last allowed wait cycle
    assign wd_hit_c = (wd_cnt == WD_W'(WD_CYCLES - 1));
`endif

    // Words are only taken while loading and the steering stage is idle
    assign bus.in_ready = (state == S_LOAD) && bus.calc_ready && !rst;
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Loader FSM with registered code-RAM, run and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_LOAD;
            wptr          <= '0;
            bus.ld_wr     <= 1'b0;
            bus.ld_addr   <= '0;
            bus.ld_data   <= '0;
            bus.start     <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.prog_len  <= '0;
            bus.err_ovf   <= 1'b0;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
            bus.res_timeout <= 1'b0;
            wd_cnt          <= '0;
`endif
        end else begin
            bus.ld_wr <= 1'b0;
            bus.start <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept_c) begin
                        bus.ld_wr   <= 1'b1;
                        bus.ld_addr <= wptr;
                        bus.ld_data <= bus.in_data;
                        if (wptr == '0) begin
                            bus.err_ovf <= 1'b0;
                        end
                        // A full code RAM ends the program without wrapping
                        if (bus.in_last || (wptr == WPTR_MAX)) begin
                            bus.prog_len <= wptr;
                            state        <= S_START;
                            if (!bus.in_last) begin
                                bus.err_ovf <= 1'b1;
                            end
                        end else begin
                            wptr <= wptr + M'(1);
                        end
                    end
                end
                S_START: begin
                    bus.start <= 1'b1;
                    state     <= S_WAIT_BUSY;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
                    wd_cnt    <= '0;
`endif
                end
                S_WAIT_BUSY: begin
`ifdef PROGRAM_LOADER_WATCHDOG_EN
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (wd_hit_c) begin
                        bus.res_data    <= bus.calc_out;
                        bus.res_valid   <= 1'b1;
                        bus.res_timeout <= 1'b1;
                        state           <= S_RESULT;
                    end else
`endif
                    if (!bus.calc_ready) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.calc_ready) begin
                        bus.res_data  <= bus.calc_out;
                        bus.res_valid <= 1'b1;
                        state         <= S_RESULT;
                    end
`ifdef PROGRAM_LOADER_WATCHDOG_EN
                    else if (wd_hit_c) begin
                        bus.res_data    <= bus.calc_out;
                        bus.res_valid   <= 1'b1;
                        bus.res_timeout <= 1'b1;
                        state           <= S_RESULT;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_RESULT: begin
                    if (bus.res_valid && bus.res_ready) begin
                        bus.res_valid <= 1'b0;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
                        bus.res_timeout <= 1'b0;
`endif
                        wptr          <= '0;
                        state         <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: program_loader with a 4-word code RAM (M=2) against a
// bench-side model of in_ready/write sequencing and a result scoreboard.
module tb_program_loader;
    localparam int unsigned N   = 16;
    localparam int unsigned M   = 2;
    localparam int unsigned CAP = 1 << M;
`ifdef PROGRAM_LOADER_WATCHDOG_EN
    localparam int unsigned WD  = 8;
`endif

    logic clk = 1'b0;
    logic rst;

    program_loader_if #(.N(N), .M(M)) bus ();

    program_loader #(
        .N(N), .M(M)
`ifdef PROGRAM_LOADER_WATCHDOG_EN
        , .WD_CYCLES(WD)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [M-1:0] addr;
        logic [N-1:0] data;
    } wr_t;

    // Cycle vector: inputs, then outputs after the clock edge
    typedef struct {
        logic         v;
        logic [N-1:0] d;
        logic         last;
        logic         cr;
        logic [N-1:0] co;
        logic         rr;
        logic         rdy;
        logic         wr;
        logic [M-1:0] addr;
        logic [N-1:0] data;
        logic         st;
        logic         rv;
        logic [N-1:0] rd;
        logic [M-1:0] plen;
    } vec_t;

    wr_t          wq[$];
    logic [N-1:0] rq[$];
    int           total = 0;
    int           bad   = 0;

    // Bench model of the loader's load-side state
    bit exp_load = 1'b1;
    int exp_wptr = 0;
    int exp_plen = 0;
    bit exp_ovf  = 1'b0;
    bit acc_flag = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply current inputs for one clock; model acceptance and queue writes
    task automatic step();
        logic exp_rdy;
        #1;
        exp_rdy  = exp_load && bus.calc_ready && !rst;
        acc_flag = 1'b0;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (bus.in_valid && exp_rdy) begin
            acc_flag = 1'b1;
            wq.push_back('{addr: M'(exp_wptr), data: bus.in_data});
            if (exp_wptr == 0) exp_ovf = 1'b0;
            if (bus.in_last || exp_wptr == int'(CAP - 1)) begin
                if (!bus.in_last) exp_ovf = 1'b1;
                exp_plen = exp_wptr;
                exp_load = 1'b0;
            end else begin
                exp_wptr++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Every code-RAM write must match the next expected word
    always @(negedge clk) begin
        if (bus.ld_wr) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ld_wr_unexpected: got addr %0h data %0h expected no write", bus.ld_addr, bus.ld_data);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("ld_addr", 32'(bus.ld_addr), 32'(e.addr));
                chk("ld_data", 32'(bus.ld_data), 32'(e.data));
            end
            chk("start_with_ld_wr", 32'(bus.start), 32'(0));
        end
    end

    task automatic check_zero_outputs();
        chk("rst_ld_wr",     32'(bus.ld_wr),     32'(0));
        chk("rst_start",     32'(bus.start),     32'(0));
        chk("rst_res_valid", 32'(bus.res_valid), 32'(0));
        chk("rst_res_data",  32'(bus.res_data),  32'(0));
        chk("rst_ld_addr",   32'(bus.ld_addr),   32'(0));
        chk("rst_ld_data",   32'(bus.ld_data),   32'(0));
        chk("rst_prog_len",  32'(bus.prog_len),  32'(0));
        chk("rst_err_ovf",   32'(bus.err_ovf),   32'(0));
`ifdef PROGRAM_LOADER_WATCHDOG_EN
        chk("rst_res_timeout", 32'(bus.res_timeout), 32'(0));
`endif
    endtask

    task automatic load_words(input int n, input bit toggle, input int low_first,
                              input logic [N-1:0] base, input bit mark_last);
        int k = 0;
        for (int cyc = 0; cyc < 64 && k < n; cyc++) begin
            bus.calc_ready = (cyc >= low_first);
            bus.in_valid   = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.in_data    = base + N'(k);
            bus.in_last    = mark_last && (k == n - 1);
            step();
            if (acc_flag) k++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("load_count", 32'(k), 32'(n));
    endtask

    task automatic wait_start();
        int n = 0;
        bus.calc_ready = 1'b1;
        bus.res_ready  = 1'b0;
        do begin
            step();
            n++;
        end while (!bus.start && n < 6);
        chk("start_pulse", 32'(bus.start), 32'(1));
        chk("writes_drained", 32'(wq.size()), 32'(0));
    endtask

    // Steering model: busy for 'low' cycles, then report 'result'
    task automatic finish_run(input logic [N-1:0] result, input int low, input int bp);
        wait_start();
        chk("prog_len", 32'(bus.prog_len), 32'(exp_plen));
        chk("err_ovf",  32'(bus.err_ovf),  32'(exp_ovf));
        bus.calc_ready = 1'b0;
        for (int i = 0; i < low; i++) begin
            step();
            if (i == 0) chk("start_one_cycle", 32'(bus.start), 32'(0));
            chk("res_valid_busy", 32'(bus.res_valid), 32'(0));
        end
        bus.calc_ready = 1'b1;
        bus.calc_out   = result;
        rq.push_back(result);
        step();
        bus.calc_out = ~result;
        chk("res_valid_rise", 32'(bus.res_valid), 32'(1));
`ifdef PROGRAM_LOADER_WATCHDOG_EN
        chk("res_timeout_clear", 32'(bus.res_timeout), 32'(0));
`endif
        for (int i = 0; i < bp; i++) begin
            step();
            chk("res_valid_hold", 32'(bus.res_valid), 32'(1));
            chk("res_data_hold",  32'(bus.res_data),  32'(rq[0]));
        end
        chk("res_data", 32'(bus.res_data), 32'(rq.pop_front()));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_load = 1'b1;
        exp_wptr = 0;
        chk("res_valid_drop", 32'(bus.res_valid), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tv[11];
        // v d last cr co rr | rdy wr addr data st rv rd plen
        tv[0]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0003, 1'b0, 1'b0, 16'h0000, 2'd0};
        tv[1]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd1, 16'h0004, 1'b0, 1'b0, 16'h0000, 2'd0};
        tv[2]  = '{1'b1, 16'h8002, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd2, 16'h8002, 1'b0, 1'b0, 16'h0000, 2'd0};
        tv[3]  = '{1'b1, 16'hC000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd3, 16'hC000, 1'b0, 1'b0, 16'h0000, 2'd3};
        tv[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'hC000, 1'b1, 1'b0, 16'h0000, 2'd3};
        tv[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'hC000, 1'b0, 1'b0, 16'h0000, 2'd3};
        tv[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'hC000, 1'b0, 1'b0, 16'h0000, 2'd3};
        tv[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'hC000, 1'b0, 1'b0, 16'h0000, 2'd3};
        tv[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 2'd3, 16'hC000, 1'b0, 1'b1, 16'h0007, 2'd3};
        tv[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b0, 2'd3, 16'hC000, 1'b0, 1'b0, 16'h0007, 2'd3};
        tv[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd3, 16'hC000, 1'b0, 1'b0, 16'h0007, 2'd3};

        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.in_last    = 1'b0;
        bus.calc_out   = '0;
        bus.calc_ready = 1'b1;
        bus.res_ready  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check_zero_outputs();

        // Cycle-exact first program
        for (int i = 0; i < 11; i++) begin
            bus.in_valid   = tv[i].v;
            bus.in_data    = tv[i].d;
            bus.in_last    = tv[i].last;
            bus.calc_ready = tv[i].cr;
            bus.calc_out   = tv[i].co;
            bus.res_ready  = tv[i].rr;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tv[i].rdy));
            step();
            if (tv[i].rr) begin
                exp_load = 1'b1;
                exp_wptr = 0;
            end
            chk($sformatf("vec%0d_ld_wr", i),     32'(bus.ld_wr),     32'(tv[i].wr));
            chk($sformatf("vec%0d_ld_addr", i),   32'(bus.ld_addr),   32'(tv[i].addr));
            chk($sformatf("vec%0d_ld_data", i),   32'(bus.ld_data),   32'(tv[i].data));
            chk($sformatf("vec%0d_start", i),     32'(bus.start),     32'(tv[i].st));
            chk($sformatf("vec%0d_res_valid", i), 32'(bus.res_valid), 32'(tv[i].rv));
            chk($sformatf("vec%0d_res_data", i),  32'(bus.res_data),  32'(tv[i].rd));
            chk($sformatf("vec%0d_prog_len", i),  32'(bus.prog_len),  32'(tv[i].plen));
        end
        chk("vec_err_ovf", 32'(bus.err_ovf), 32'(0));

        // Toggling valid while the steering stage starts busy
        load_words(3, 1'b1, 4, 16'h1000, 1'b1);
        finish_run(16'h0BEE, 2, 0);

        // Result backpressure, then in_ready tracks calc_ready
        load_words(2, 1'b0, 0, 16'h2000, 1'b1);
        finish_run(16'h1234, 3, 5);
        bus.calc_ready = 1'b0;
        step();
        bus.calc_ready = 1'b1;
        step();

        // Overflow: 4 words fill the RAM, 5th waits for the next program
        load_words(4, 1'b0, 0, 16'h3000, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3004;
        bus.in_last  = 1'b0;
        finish_run(16'hAAAA, 1, 2);
        load_words(2, 1'b0, 0, 16'h3004, 1'b1);
        finish_run(16'h5555, 1, 0);

        // Reset while waiting for the run to finish
        load_words(4, 1'b0, 0, 16'h4000, 1'b0);
        wait_start();
        chk("pre_rst_err_ovf", 32'(bus.err_ovf), 32'(1));
        bus.calc_ready = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        bus.calc_ready = 1'b1;
        step();
        rst = 1'b0;
        exp_load = 1'b1;
        exp_wptr = 0;
        exp_ovf  = 1'b0;
        check_zero_outputs();
        load_words(1, 1'b0, 0, 16'h4100, 1'b1);
        finish_run(16'h0042, 1, 0);

`ifdef PROGRAM_LOADER_WATCHDOG_EN
        // Watchdog fires with the steering stage stuck busy
        load_words(1, 1'b0, 0, 16'h5000, 1'b1);
        wait_start();
        bus.calc_ready = 1'b0;
        bus.calc_out   = 16'h5A5A;
        for (int i = 1; i <= int'(WD); i++) begin
            step();
            chk($sformatf("wd_res_valid_%0d", i), 32'(bus.res_valid), 32'(i == int'(WD)));
        end
        chk("wd_res_timeout", 32'(bus.res_timeout), 32'(1));
        chk("wd_res_data",    32'(bus.res_data),    32'(16'h5A5A));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_load = 1'b1;
        exp_wptr = 0;
        chk("wd_res_valid_drop",   32'(bus.res_valid),   32'(0));
        chk("wd_res_timeout_drop", 32'(bus.res_timeout), 32'(0));
        step();
        bus.calc_ready = 1'b1;
        step();
`endif

        chk("writes_left", 32'(wq.size()), 32'(0));
        chk("results_left", 32'(rq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
